// File: rtl/int_issue_queue.sv
// Integer issue queue: DEPTH entries with CDB wakeup, dispatch bypass and single issue per cycle.
// Optional ISSUEQ_AGE_SELECT_EN selects the oldest ready entry instead of the lowest index.
module int_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dispatch_en,
    input  logic [3:0]       dispatch_opcode,
    input  logic [31:0]      dispatch_rsdata,
    input  logic [31:0]      dispatch_rtdata,
    input  logic [TAG_W-1:0] dispatch_rstag,
    input  logic [TAG_W-1:0] dispatch_rttag,
    input  logic             dispatch_rsvalid,
    input  logic             dispatch_rtvalid,
    input  logic [TAG_W-1:0] dispatch_rdtag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tagout,
    input  logic [31:0]      cdb_out,
    input  logic             issue_int,
    output logic             ready_int,
    output logic [3:0]       issueq_opcode,
    output logic [31:0]      issueq_rsdata,
    output logic [31:0]      issueq_rtdata,
    output logic [TAG_W-1:0] issueq_rdtag,
    output logic             issueq_full,
    output logic [3:0]       issueq_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] rs_rdy_q;
    logic [DEPTH-1:0] rt_rdy_q;
    logic [3:0]       opcode_q  [DEPTH];
    logic [31:0]      rs_data_q [DEPTH];
    logic [31:0]      rt_data_q [DEPTH];
    logic [TAG_W-1:0] rs_tag_q  [DEPTH];
    logic [TAG_W-1:0] rt_tag_q  [DEPTH];
    logic [TAG_W-1:0] rd_tag_q  [DEPTH];
    logic [3:0]       count_q;

`ifdef ISSUEQ_AGE_SELECT_EN
    localparam int unsigned SEQ_W = IDX_W + 1;

    logic [SEQ_W-1:0] seq_q [DEPTH];
    logic [SEQ_W-1:0] seq_cnt_q;

    // a is older than b when (a - b) is negative modulo 2^SEQ_W
    function automatic logic is_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] diff;
        diff = a - b;
        return diff[SEQ_W-1];
    endfunction
`endif

    logic [DEPTH-1:0] ready_vec;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic [IDX_W-1:0] free_idx;
    logic             dispatch_ok;
    logic             issue_ok;
    logic             rs_bypass;
    logic             rt_bypass;

    assign ready_vec   = valid_q & rs_rdy_q & rt_rdy_q;
    assign ready_int   = |ready_vec;
    assign issueq_full = (count_q == 4'(DEPTH));
    assign issueq_count = count_q;
    assign dispatch_ok = dispatch_en & ~issueq_full;
    assign issue_ok    = issue_int & ready_int;
    assign rs_bypass   = cdb_valid & ~dispatch_rsvalid & (dispatch_rstag == cdb_tagout);
    assign rt_bypass   = cdb_valid & ~dispatch_rtvalid & (dispatch_rttag == cdb_tagout);

    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef ISSUEQ_AGE_SELECT_EN
            if (ready_vec[i] && (!sel_found || is_older(seq_q[i], seq_q[sel_idx]))) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
`else
            if (ready_vec[i] && !sel_found) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
`endif
        end
    end

    // Target uses registered valid bits, so an entry freed this cycle is never reused this cycle
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        issueq_opcode = '0;
        issueq_rsdata = '0;
        issueq_rtdata = '0;
        issueq_rdtag  = '0;
        if (ready_int) begin
            issueq_opcode = opcode_q[sel_idx];
            issueq_rsdata = rs_data_q[sel_idx];
            issueq_rtdata = rt_data_q[sel_idx];
            issueq_rdtag  = rd_tag_q[sel_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_ok && sel_idx == IDX_W'(i)) begin
                    valid_q[i] <= 1'b0;
                end
                if (dispatch_ok && free_idx == IDX_W'(i)) begin
                    valid_q[i] <= 1'b1;
                end
            end
            unique case ({dispatch_ok, issue_ok})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef ISSUEQ_AGE_SELECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_cnt_q <= '0;
        end else if (dispatch_ok) begin
            seq_cnt_q <= seq_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (dispatch_ok && free_idx == IDX_W'(i)) begin
                seq_q[i] <= seq_cnt_q;
            end
        end
    end
`endif

    // Payload is only meaningful under a valid bit, so it carries no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && cdb_valid && !rs_rdy_q[i] && rs_tag_q[i] == cdb_tagout) begin
                rs_data_q[i] <= cdb_out;
                rs_rdy_q[i]  <= 1'b1;
            end
            if (valid_q[i] && cdb_valid && !rt_rdy_q[i] && rt_tag_q[i] == cdb_tagout) begin
                rt_data_q[i] <= cdb_out;
                rt_rdy_q[i]  <= 1'b1;
            end
            if (dispatch_ok && free_idx == IDX_W'(i)) begin
                opcode_q[i]  <= dispatch_opcode;
                rs_tag_q[i]  <= dispatch_rstag;
                rt_tag_q[i]  <= dispatch_rttag;
                rd_tag_q[i]  <= dispatch_rdtag;
                rs_rdy_q[i]  <= dispatch_rsvalid | rs_bypass;
                rt_rdy_q[i]  <= dispatch_rtvalid | rt_bypass;
                rs_data_q[i] <= dispatch_rsvalid ? dispatch_rsdata :
                                (rs_bypass ? cdb_out : '0);
                rt_data_q[i] <= dispatch_rtvalid ? dispatch_rtdata :
                                (rt_bypass ? cdb_out : '0);
            end
        end
    end

endmodule

// File: doc/int_issue_queue.md
INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; legal values 2..8.
REQ-002 Parameter TAG_W, default 6: width of the physical tag.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 dispatch_en  input  1  write request for one instruction into the queue.
REQ-006 dispatch_opcode  input  4  integer opcode.
REQ-007 dispatch_rsdata / dispatch_rtdata  input  32 each  operand data, meaningful only when the matching valid bit is 1.
REQ-008 dispatch_rstag / dispatch_rttag  input  TAG_W each  producer tags for operands that are not yet ready.
REQ-009 dispatch_rsvalid / dispatch_rtvalid  input  1 each  1 = operand data is present.
REQ-010 dispatch_rdtag  input  TAG_W  destination tag.
REQ-011 cdb_valid  input  1; cdb_tagout  input  TAG_W; cdb_out  input  32: CDB broadcast.
REQ-012 issue_int  input  1  grant from the issue unit.
REQ-013 ready_int  output  1  a selected entry is ready to issue.
REQ-014 issueq_opcode  output  4; issueq_rsdata, issueq_rtdata  output  32 each; issueq_rdtag  output  TAG_W: fields of the selected entry.
REQ-015 issueq_full  output  1; issueq_count  output  4  number of valid entries.

Function
REQ-016 Each entry SHALL hold: valid, opcode, rs{data,tag,rdy}, rt{data,tag,rdy}, rdtag, and a sequence number.
REQ-017 Dispatch: when dispatch_en=1 and issueq_full=0, the instruction SHALL be written to the lowest-index invalid entry at the next edge.
REQ-018 Dispatch while issueq_full=1 SHALL be ignored, with no state change; full is evaluated before the edge, even if issue_int frees an entry in the same cycle.
REQ-019 Wakeup: when cdb_valid=1, every valid entry operand with rdy=0 and a tag equal to cdb_tagout SHALL capture cdb_out and set rdy=1 at the next edge.
REQ-020 Dispatch bypass: an operand dispatched with valid=0 whose tag equals cdb_tagout while cdb_valid=1 in the same cycle SHALL be written with rdy=1 and data=cdb_out.
REQ-021 An entry is ready when valid & rs.rdy & rt.rdy, using registered state only; a wakeup in cycle N therefore makes the entry ready in cycle N+1.
REQ-022 ready_int SHALL be combinational and equal to the OR of the entry ready bits.
REQ-023 Output data fields SHALL present the selected entry combinationally, and SHALL be all-zero when ready_int=0.
REQ-024 Issue: issue_int=1 while ready_int=1 SHALL clear the selected entry's valid bit at the next edge.
REQ-025 issue_int=1 while ready_int=0 SHALL be ignored.
REQ-026 Simultaneous dispatch and issue with the queue not full: both SHALL take effect in the same cycle; the freed entry SHALL NOT be the dispatch target in that cycle.
REQ-027 issueq_count SHALL be registered: +1 on an accepted dispatch, -1 on an accepted issue, unchanged when both occur.
REQ-028 issueq_full SHALL equal (issueq_count == DEPTH).
REQ-029 The sequence counter (width log2(DEPTH)+1) SHALL increment on each accepted dispatch, wrap modulo 2^width, and be stored into the written entry.

Reset
REQ-030 On reset low, the following SHALL clear asynchronously: all valid bits, issueq_count, and the sequence counter. ready_int and all data outputs SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first dispatch after release SHALL go to entry 0.

Configuration
REQ-032 Macro ISSUEQ_AGE_SELECT_EN defined: selection SHALL pick the oldest ready entry, by wrap-aware sequence-number compare.
REQ-033 Macro ISSUEQ_AGE_SELECT_EN undefined: selection SHALL pick the lowest-index ready entry; sequence numbers are unused and may be optimised away.

Verification
REQ-034 Reset, then dispatch add rs=5, rt=7 (both valid) -> next cycle ready_int=1, issueq_rsdata=5, issueq_rtdata=7, count=1; issue_int=1 -> count=0, ready_int=0.
REQ-035 Dispatch with rs waiting on tag 0x12; CDB broadcasts tag 0x12 with data 0xDEAD -> ready_int=1 one cycle after the broadcast, issueq_rsdata=0xDEAD.
REQ-036 Dispatch rt tag 0x05 in the same cycle that CDB broadcasts tag 0x05 with data 0x77 -> entry becomes ready the next cycle with rtdata=0x77 (bypass).
REQ-037 Fill all 4 entries -> full=1; a 5th dispatch together with issue_int -> dispatch dropped, count=3, full=0.
REQ-038 With ISSUEQ_AGE_SELECT_EN: dispatch A into entry 0, B into entry 1; issue A; dispatch C into entry 0; make B and C ready together -> B issues first. Without the macro -> C issues first.
REQ-039 Assert reset while 3 entries are valid -> count=0 and ready_int=0 immediately; after release, the next dispatch lands in entry 0.
